// File: rtl/corner_list_buffer_pkg.sv
// Shared record layout for the corner list buffer: field offsets, record type codes
// and small packing helpers used by the buffer top.
package corner_list_buffer_pkg;

    localparam int COORD_W = 10;
    localparam int CNT_W   = 11;
    localparam int REC_W   = 21;

    localparam int TYPE_BIT = 20;
    localparam int Y_LSB    = 10;
    localparam int X_LSB    = 0;
    localparam int CNT_LSB  = 0;

    localparam int FLAG_FIFO_DROP = 11;
    localparam int FLAG_CAPPED    = 12;
    localparam int FLAG_TRUNC     = 13;

    localparam logic TYPE_CORNER  = 1'b0;
    localparam logic TYPE_TRAILER = 1'b1;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    function automatic logic [REC_W-1:0] pack_corner(input logic [COORD_W-1:0] x,
                                                     input logic [COORD_W-1:0] y);
        logic [REC_W-1:0] r;
        r = '0;
        r[TYPE_BIT]            = TYPE_CORNER;
        r[Y_LSB +: COORD_W]    = y;
        r[X_LSB +: COORD_W]    = x;
        return r;
    endfunction

    function automatic logic [REC_W-1:0] pack_trailer(input logic [CNT_W-1:0] cnt,
                                                      input logic fifo_drop,
                                                      input logic capped,
                                                      input logic truncated);
        logic [REC_W-1:0] r;
        r = '0;
        r[TYPE_BIT]          = TYPE_TRAILER;
        r[CNT_LSB +: CNT_W]  = cnt;
        r[FLAG_FIFO_DROP]    = fifo_drop;
        r[FLAG_CAPPED]       = capped;
        r[FLAG_TRUNC]        = truncated;
        return r;
    endfunction

endpackage

// File: rtl/corner_list_buffer_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry lives in a registered output stage,
// so a write into an empty FIFO is visible on rd_data right after that edge.
module sync_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      mem_cnt;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             pop;
    logic             refill;
    logic             bypass;

    // count includes the output stage; mem_cnt is what still sits in the array
    assign mem_cnt = count - {{AW{1'b0}}, out_valid};
    assign pop     = out_valid & rd_en;
    assign refill  = ~out_valid | pop;
    assign bypass  = wr_en & refill & (mem_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            if (refill) begin
                if (mem_cnt != '0) begin
                    out_data  <= mem[rd_ptr];
                    out_valid <= 1'b1;
                    rd_ptr    <= rd_ptr + 1'b1;
                end else if (wr_en) begin
                    out_data  <= wr_data;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            if (wr_en && !bypass) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !bypass) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data   = out_data;
    assign empty     = ~out_valid;
    assign full      = (count == (AW+1)'(DEPTH));
    assign occupancy = count;

endmodule

// File: rtl/corner_list_buffer.sv
// Packs NMS corner pixels into a record stream with one trailer per frame, buffered
// behind a valid/ready handshake so the host can back-pressure bursty corner output.
module corner_list_buffer
    import corner_list_buffer_pkg::*;
#(
    parameter int COL_NUM     = 640,
    parameter int ROW_NUM     = 480,
    parameter int FIFO_DEPTH  = 256,
    parameter int MAX_CORNERS = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               iscorner,
    input  logic [COORD_W-1:0] x_coord,
    input  logic [COORD_W-1:0] y_coord,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [REC_W-1:0]   m_data,
    output logic [15:0]        frame_cnt,
    output logic               drop_sticky
);

    localparam int                 OCC_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(COL_NUM - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(ROW_NUM - 1);
    localparam logic [OCC_W-1:0]   OCC_LIM  = OCC_W'(FIFO_DEPTH - 2);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(MAX_CORNERS);

    logic               vld_p1;
    logic               corner_p1;
    logic               sof_p1;
    logic               eof_p1;
    logic [COORD_W-1:0] x_p1;
    logic [COORD_W-1:0] y_p1;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   cnt_eff;
    logic               fifo_drop_f;
    logic               capped_f;

    logic               start_frame, end_frame, trailer, truncated, take;
    logic               accept, cap_hit, fifo_hit;
    logic               wr_req, fifo_wr, fifo_full, fifo_empty, room;
    logic [REC_W-1:0]   wr_rec;
    logic [OCC_W-1:0]   occupancy;

    // ---- stage p1: registered pixel with frame markers ----
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= ce;
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            corner_p1 <= iscorner;
            x_p1      <= x_coord;
            y_p1      <= y_coord;
            sof_p1    <= (x_coord == '0) && (y_coord == '0);
            eof_p1    <= (x_coord == X_LAST) && (y_coord == Y_LAST);
        end
    end

    // ---- stage p2: frame decisions and FIFO write ----
    // Corners need two free slots so the trailer always has one left.
    assign room = (occupancy <= OCC_LIM);

    always_comb begin
        start_frame = 1'b0;
        end_frame   = 1'b0;
        trailer     = 1'b0;
        truncated   = 1'b0;
        take        = 1'b0;
        if (vld_p1) begin
            case (state)
                WAIT_SOF: begin
                    if (sof_p1) begin
                        start_frame = 1'b1;
                        take        = corner_p1 & ~eof_p1;
                    end
                end
                IN_FRAME: begin
                    if (sof_p1) begin
                        trailer     = 1'b1;
                        truncated   = 1'b1;
                        start_frame = 1'b1;
                    end else if (eof_p1) begin
                        trailer     = 1'b1;
                        end_frame   = 1'b1;
                    end else begin
                        take        = corner_p1;
                    end
                end
                default: ;
            endcase
        end
        cnt_eff  = start_frame ? '0 : count;
        cap_hit  = take & (cnt_eff == CNT_MAX);
        fifo_hit = take & ~cap_hit & ~room;
        accept   = take & ~cap_hit & room;
        wr_req   = trailer | accept;
        wr_rec   = trailer ? pack_trailer(count, fifo_drop_f, capped_f, truncated)
                           : pack_corner(x_p1, y_p1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_SOF;
            count       <= '0;
            fifo_drop_f <= 1'b0;
            capped_f    <= 1'b0;
            frame_cnt   <= '0;
            drop_sticky <= 1'b0;
        end else begin
            if (start_frame) begin
                state       <= IN_FRAME;
                count       <= accept ? CNT_W'(1) : '0;
                fifo_drop_f <= fifo_hit;
                capped_f    <= cap_hit;
            end else begin
                if (accept)    count       <= count + CNT_W'(1);
                if (fifo_hit)  fifo_drop_f <= 1'b1;
                if (cap_hit)   capped_f    <= 1'b1;
                if (end_frame) state       <= WAIT_SOF;
            end
            if (trailer)  frame_cnt   <= frame_cnt + 16'd1;
            if (fifo_hit) drop_sticky <= 1'b1;
        end
    end

    assign fifo_wr = wr_req & (~fifo_full | (m_valid & m_ready));
    assign m_valid = ~fifo_empty;

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (fifo_wr),
        .wr_data   (wr_rec),
        .rd_en     (m_ready),
        .rd_data   (m_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (occupancy)
    );

endmodule

// File: tb/tb_corner_list_buffer.sv
// Scoreboard bench for corner_list_buffer on an 8x6 frame with a 4-entry FIFO and
// a 4-corner cap; a reference model queues expected records as pixels are driven.
module tb_corner_list_buffer;

    localparam int COLS  = 8;
    localparam int ROWS  = 6;
    localparam int DEPTH = 4;
    localparam int MAXC  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        iscorner = 1'b0;
    logic [9:0]  x_coord = '0;
    logic [9:0]  y_coord = '0;
    logic        m_ready = 1'b1;
    logic        m_valid;
    logic [20:0] m_data;
    logic [15:0] frame_cnt;
    logic        drop_sticky;

    int n_tests = 0;
    int n_fail  = 0;

    corner_list_buffer #(
        .COL_NUM     (COLS),
        .ROW_NUM     (ROWS),
        .FIFO_DEPTH  (DEPTH),
        .MAX_CORNERS (MAXC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .iscorner    (iscorner),
        .x_coord     (x_coord),
        .y_coord     (y_coord),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .frame_cnt   (frame_cnt),
        .drop_sticky (drop_sticky)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---- reference model state ----
    logic [20:0] exp_q[$];
    logic [20:0] got_q[$];
    int  occ = 0;
    bit  st_v = 0, st_c = 0, st_sof = 0, st_eof = 0;
    int  st_x = 0, st_y = 0;
    bit  in_frame = 0;
    int  mcnt = 0;
    bit  mfd = 0, mcap = 0, msticky = 0;
    int  mframes = 0;
    bit  push_m, pop_m;
    bit  prev_valid = 0;
    logic [20:0] prev_data = '0;
    logic [47:0] cmap = '0;
    bit  rand_rdy = 0;

    function automatic logic [20:0] mk_corner(input int x, input int y);
        return 21'(y * 1024 + x);
    endfunction

    function automatic logic [20:0] mk_trailer(input int cnt, input bit fd, input bit cap, input bit tr);
        return 21'((1 << 20) + (tr << 13) + (cap << 12) + (fd << 11) + cnt);
    endfunction

    task automatic model_corner();
        if (st_c) begin
            if (mcnt == MAXC) mcap = 1;
            else if (DEPTH - occ < 2) begin mfd = 1; msticky = 1; end
            else begin
                exp_q.push_back(mk_corner(st_x, st_y));
                push_m = 1;
                mcnt++;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                occ = 0; exp_q.delete(); st_v = 0; in_frame = 0;
                mcnt = 0; mfd = 0; mcap = 0; msticky = 0; mframes = 0;
            end else begin
                pop_m  = m_ready && (occ > 0);
                push_m = 0;
                if (prev_valid && m_ready) begin
                    check_eq("rec_pending", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check_eq("record", prev_data, exp_q.pop_front());
                    got_q.push_back(prev_data);
                end
                if (st_v) begin
                    if (!in_frame) begin
                        if (st_sof) begin
                            in_frame = 1; mcnt = 0; mfd = 0; mcap = 0;
                            model_corner();
                        end
                    end else if (st_sof) begin
                        exp_q.push_back(mk_trailer(mcnt, mfd, mcap, 1));
                        push_m = 1; mframes++;
                        mcnt = 0; mfd = 0; mcap = 0;
                    end else if (st_eof) begin
                        exp_q.push_back(mk_trailer(mcnt, mfd, mcap, 0));
                        push_m = 1; mframes++; in_frame = 0;
                    end else begin
                        model_corner();
                    end
                end
                occ = occ + int'(push_m) - int'(pop_m);
                st_v = ce;
                if (ce) begin
                    st_c = iscorner; st_x = int'(x_coord); st_y = int'(y_coord);
                    st_sof = (x_coord == 0) && (y_coord == 0);
                    st_eof = (x_coord == COLS - 1) && (y_coord == ROWS - 1);
                end
                if (prev_valid && !m_ready) check_eq("hold", m_data, prev_data);
            end
            check_eq("m_valid", m_valid, occ > 0);
            check_eq("frame_cnt", frame_cnt, 32'(mframes & 16'hFFFF));
            check_eq("drop_sticky", drop_sticky, msticky);
            prev_valid = m_valid;
            prev_data  = m_data;
        end
    end

    // ---- stimulus ----
    task automatic pix(input bit v, input bit c, input int x, input int y);
        @(negedge clk);
        ce = v; iscorner = c; x_coord = 10'(x); y_coord = 10'(y);
        if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pix(0, 0, 0, 0);
    endtask

    task automatic run_pixels(input int first, input int last);
        for (int p = first; p < last; p++) pix(1, cmap[p], p % COLS, p / COLS);
    endtask

    task automatic set_corner(input int x, input int y);
        cmap[y * COLS + x] = 1'b1;
    endtask

    initial begin
        idle(3);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_data", m_data, 0);
        check_eq("rst_frame_cnt", frame_cnt, 0);
        check_eq("rst_sticky", drop_sticky, 0);
        @(negedge clk); rst = 1'b0;
        idle(2);

        // basic frame, two corners
        m_ready = 1'b1; cmap = '0; set_corner(3, 2); set_corner(4, 3);
        got_q.delete();
        run_pixels(0, COLS * ROWS); idle(6);
        check_eq("t1_nrec", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check_eq("t1_c0", got_q[0], 21'h00803);
            check_eq("t1_c1", got_q[1], 21'h00C04);
            check_eq("t1_trl", got_q[2], 21'h100002);
        end
        check_eq("t1_frames", frame_cnt, 1);

        // FIFO overflow with consumer stalled
        m_ready = 1'b0; cmap = '0;
        for (int i = 1; i <= 5; i++) set_corner(i, 1);
        got_q.delete();
        run_pixels(0, COLS * ROWS); idle(3);
        check_eq("t2_sticky", drop_sticky, 1);
        check_eq("t2_full_valid", m_valid, 1);
        m_ready = 1'b1; idle(8);
        check_eq("t2_nrec", got_q.size(), 4);
        if (got_q.size() == 4) check_eq("t2_trl", got_q[3], 21'h100803);

        // per-frame cap
        cmap = '0;
        for (int i = 1; i <= 6; i++) set_corner(i, 2);
        got_q.delete();
        run_pixels(0, COLS * ROWS); idle(6);
        check_eq("t3_nrec", got_q.size(), 5);
        if (got_q.size() == 5) check_eq("t3_trl", got_q[4], 21'h101004);

        // truncated frame: sof at pixel 20 carrying a corner
        cmap = '0; set_corner(3, 1);
        got_q.delete();
        run_pixels(0, 20);
        pix(1, 1, 0, 0);
        cmap = '0; set_corner(2, 2); set_corner(5, 4);
        run_pixels(1, COLS * ROWS); idle(6);
        check_eq("t4_nrec", got_q.size(), 5);
        if (got_q.size() == 5) begin
            check_eq("t4_trunc", got_q[1], 21'h102001);
            check_eq("t4_trl", got_q[4], 21'h100002);
        end
        check_eq("t4_frames", frame_cnt, 5);

        // ce=0 pixels never count
        got_q.delete();
        for (int i = 0; i < 30; i++) pix(0, 1, (i % 3 == 0) ? 0 : $urandom_range(0, 7), (i % 3 == 0) ? 0 : $urandom_range(0, 5));
        idle(3);
        check_eq("t5_no_rec", got_q.size(), 0);

        // reset with three records buffered
        m_ready = 1'b0; cmap = '0; set_corner(1, 1); set_corner(2, 1); set_corner(3, 1);
        run_pixels(0, 16); idle(2);
        check_eq("t5_buffered", m_valid, 1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_eq("t5_rst_valid", m_valid, 0);
        check_eq("t5_rst_frames", frame_cnt, 0);
        check_eq("t5_rst_sticky", drop_sticky, 0);
        m_ready = 1'b1; cmap = '0; set_corner(5, 3);
        got_q.delete();
        run_pixels(20, COLS * ROWS); idle(4);
        check_eq("t5_wait_sof", got_q.size(), 0);
        cmap = '0; set_corner(2, 2);
        run_pixels(0, COLS * ROWS); idle(6);
        check_eq("t5_after_sof", got_q.size(), 2);
        check_eq("t5_frames", frame_cnt, 1);

        // random back-pressure over three frames
        rand_rdy = 1;
        for (int f = 0; f < 3; f++) begin
            cmap = '0;
            for (int y = 1; y < ROWS - 1; y++)
                for (int x = 1; x < COLS - 1; x++)
                    if ($urandom_range(0, 9) < 3) set_corner(x, y);
            run_pixels(0, COLS * ROWS);
            idle($urandom_range(0, 4));
        end
        rand_rdy = 0; m_ready = 1'b1;
        idle(12);
        check_eq("t6_frames", frame_cnt, 4);
        check_eq("t6_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
